fsm_control_unit: RTL and testbench

- Multicycle control unit for the 32-bit accumulator-less RISC core.
- Sequences fetch, decode, execute, memory and writeback states from the 4-bit opcode held in the instruction register.
- Drives all datapath selects and enables: PC, IR, ALU operand muxes, ALU operation, data memory and register file.
- Moore outputs derived from the current state, except branch PCWrite, which is qualified combinationally by zero_flag.

---
 rtl/fsm_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_fsm_control_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_control_unit.sv
// Multicycle control unit for the 32-bit RISC core.
// Walks fetch/decode/execute/memory/writeback states from the IR opcode and
// drives every datapath select and enable from registered per-state values.
module fsm_control_unit #(
  parameter int OPCODE_SIZE      = 4,
  parameter int ALU_CONTROL_SIZE = 4
) (
  input  logic                        clk,
  input  logic                        reboot,
  input  logic [OPCODE_SIZE-1:0]      opcode,
  input  logic                        zero_flag,
  output logic                        MemRead,
  output logic                        MemWrite,
  output logic                        ALUSrcA,
  output logic                        IorD,
  output logic                        IRWrite,
  output logic [1:0]                  ALUSrcB,
  output logic [ALU_CONTROL_SIZE-1:0] ALUOp,
  output logic                        PCWrite,
  output logic [1:0]                  PCSource,
  output logic                        RegWrite,
  output logic                        MemtoReg,
  output logic                        writeback_alu_enable,
  output logic [3:0]                  state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    ALU_WB  = 4'd4,
    MEM_RD  = 4'd5,
    LOAD_WB = 4'd6,
    MEM_WR  = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    HALT    = 4'd10
  } state_t;

  localparam logic [OPCODE_SIZE-1:0] OP_ADD  = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB  = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_AND  = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_OR   = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_XOR  = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_ADDI = OPCODE_SIZE'(5);
  localparam logic [OPCODE_SIZE-1:0] OP_LW   = OPCODE_SIZE'(6);
  localparam logic [OPCODE_SIZE-1:0] OP_SW   = OPCODE_SIZE'(7);
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ  = OPCODE_SIZE'(8);
  localparam logic [OPCODE_SIZE-1:0] OP_JMP  = OPCODE_SIZE'(9);
  localparam logic [OPCODE_SIZE-1:0] OP_HALT = OPCODE_SIZE'(15);

  localparam logic [ALU_CONTROL_SIZE-1:0] ALU_ADD = ALU_CONTROL_SIZE'(0);
  localparam logic [ALU_CONTROL_SIZE-1:0] ALU_SUB = ALU_CONTROL_SIZE'(1);

  state_t                        state_q, state_d;
  logic                          mem_read_q, mem_read_d;
  logic                          mem_write_q, mem_write_d;
  logic                          alu_src_a_q, alu_src_a_d;
  logic                          i_or_d_q, i_or_d_d;
  logic                          ir_write_q, ir_write_d;
  logic [1:0]                    alu_src_b_q, alu_src_b_d;
  logic [ALU_CONTROL_SIZE-1:0]   alu_op_q, alu_op_d;
  logic                          pc_write_q, pc_write_d;
  logic                          branch_q, branch_d;
  logic [1:0]                    pc_source_q, pc_source_d;
  logic                          reg_write_q, reg_write_d;
  logic                          mem_to_reg_q, mem_to_reg_d;
  logic                          wb_alu_en_q, wb_alu_en_d;

  // Next-state sequencing; the opcode is only looked at while in DECODE.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = EXEC_R;
          OP_ADDI: state_d = EXEC_I;
          OP_LW:   state_d = MEM_RD;
          OP_SW:   state_d = MEM_WR;
          OP_BEQ:  state_d = BRANCH;
          OP_JMP:  state_d = JUMP;
          OP_HALT: state_d = HALT;
          default: state_d = FETCH;
        endcase
      end
      EXEC_R:  state_d = ALU_WB;
      EXEC_I:  state_d = ALU_WB;
      MEM_RD:  state_d = LOAD_WB;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output values for the state being entered, so they register alongside it.
  always_comb begin
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    i_or_d_d     = 1'b0;
    ir_write_d   = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_op_d     = ALU_ADD;
    pc_write_d   = 1'b0;
    branch_d     = 1'b0;
    pc_source_d  = 2'b00;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    wb_alu_en_d  = 1'b0;
    case (state_d)
      FETCH: begin
        ir_write_d  = 1'b1;
        pc_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      EXEC_R: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = ALU_CONTROL_SIZE'(opcode[2:0]);
      end
      EXEC_I: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      ALU_WB: begin
        reg_write_d = 1'b1;
        wb_alu_en_d = 1'b1;
      end
      MEM_RD: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        i_or_d_d    = 1'b1;
        mem_read_d  = 1'b1;
      end
      LOAD_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      MEM_WR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        i_or_d_d    = 1'b1;
        mem_write_d = 1'b1;
      end
      BRANCH: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = ALU_SUB;
        pc_source_d = 2'b01;
        branch_d    = 1'b1;
      end
      JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      default: ;
    endcase
  end

  // State and output registers; reset preloads the FETCH outputs so the
  // first cycle after reboot releases already drives the fetch.
  always_ff @(posedge clk or negedge reboot) begin
    if (!reboot) begin
      state_q      <= FETCH;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      ir_write_q   <= 1'b1;
      alu_src_b_q  <= 2'b01;
      alu_op_q     <= ALU_ADD;
      pc_write_q   <= 1'b1;
      branch_q     <= 1'b0;
      pc_source_q  <= 2'b00;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wb_alu_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_a_q  <= alu_src_a_d;
      i_or_d_q     <= i_or_d_d;
      ir_write_q   <= ir_write_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      pc_write_q   <= pc_write_d;
      branch_q     <= branch_d;
      pc_source_q  <= pc_source_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      wb_alu_en_q  <= wb_alu_en_d;
    end
  end

  // While reboot is low every output is forced to zero (ALUOp=ADD); the
  // branch PC load is qualified by the live zero flag.
  assign MemRead              = reboot & mem_read_q;
  assign MemWrite             = reboot & mem_write_q;
  assign ALUSrcA              = reboot & alu_src_a_q;
  assign IorD                 = reboot & i_or_d_q;
  assign IRWrite              = reboot & ir_write_q;
  assign ALUSrcB              = reboot ? alu_src_b_q : 2'b00;
  assign ALUOp                = reboot ? alu_op_q : ALU_ADD;
  assign PCWrite              = reboot & (pc_write_q | (branch_q & zero_flag));
  assign PCSource             = reboot ? pc_source_q : 2'b00;
  assign RegWrite             = reboot & reg_write_q;
  assign MemtoReg             = reboot & mem_to_reg_q;
  assign writeback_alu_enable = reboot & wb_alu_en_q;
  assign state                = state_q;

endmodule

// File: tb/tb_fsm_control_unit.sv
// Self-checking bench for fsm_control_unit: directed literal sequences plus
// randomized opcodes/zero flag/resets checked against an instruction-path model.
module tb_fsm_control_unit;

  logic       clk = 1'b0;
  logic       reboot = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero_flag = 1'b0;
  logic       MemRead, MemWrite, ALUSrcA, IorD, IRWrite, PCWrite;
  logic       RegWrite, MemtoReg, writeback_alu_enable;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, state;

  int checks = 0;
  int errors = 0;

  fsm_control_unit #(.OPCODE_SIZE(4), .ALU_CONTROL_SIZE(4)) dut (
    .clk(clk), .reboot(reboot), .opcode(opcode), .zero_flag(zero_flag),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .IorD(IorD),
    .IRWrite(IRWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCWrite(PCWrite),
    .PCSource(PCSource), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .writeback_alu_enable(writeback_alu_enable), .state(state)
  );

  always #5 clk = ~clk;

  logic [16:0] dut_out;
  assign dut_out = {MemRead, MemWrite, ALUSrcA, IorD, IRWrite, ALUSrcB, ALUOp,
                    PCWrite, PCSource, RegWrite, MemtoReg, writeback_alu_enable};

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for a state, written straight from the per-state table.
  function automatic logic [16:0] expOut(input int st, input logic [3:0] op, input logic z);
    logic mr, mw, asa, iod, irw, pcw, rw, m2r, wb;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {mr, mw, asa, iod, irw, pcw, rw, m2r, wb} = '0;
    asb = 2'd0; pcs = 2'd0; aop = 4'd0;
    case (st)
      0: begin irw = 1; pcw = 1; asb = 2'd1; end
      2: begin asa = 1; aop = op; end
      3: begin asa = 1; asb = 2'd2; end
      4: begin rw = 1; wb = 1; end
      5: begin asa = 1; asb = 2'd2; iod = 1; mr = 1; end
      6: begin rw = 1; m2r = 1; end
      7: begin asa = 1; asb = 2'd2; iod = 1; mw = 1; end
      8: begin asa = 1; aop = 4'd1; pcs = 2'd1; pcw = z; end
      9: begin pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {mr, mw, asa, iod, irw, asb, aop, pcw, pcs, rw, m2r, wb};
  endfunction

  // Cycles from one FETCH to the next for each opcode class.
  function automatic int latency(input logic [3:0] op);
    if (op <= 4'd6) return 4;
    if (op == 4'd7 || op == 4'd8 || op == 4'd9) return 3;
    return 2;
  endfunction

  // Reference model: current state plus the remaining states of the instruction.
  int         m_cur = 0;
  int         m_rest[$];
  logic [3:0] m_op = 4'd0;

  always @(negedge reboot) begin
    m_cur = 0;
    m_rest.delete();
  end

  always @(posedge clk) begin
    if (reboot) begin
      if (m_cur == 0) m_cur = 1;
      else if (m_cur == 10) m_cur = 10;
      else if (m_cur == 1) begin
        m_op = opcode;
        m_rest.delete();
        if (opcode <= 4'd4) m_rest = '{2, 4};
        else if (opcode == 4'd5) m_rest = '{3, 4};
        else if (opcode == 4'd6) m_rest = '{5, 6};
        else if (opcode == 4'd7) m_rest = '{7};
        else if (opcode == 4'd8) m_rest = '{8};
        else if (opcode == 4'd9) m_rest = '{9};
        else if (opcode == 4'd15) m_rest = '{10};
        if (opcode != 4'd15) m_rest.push_back(0);
        m_cur = m_rest.pop_front();
      end else if (m_rest.size() > 0) m_cur = m_rest.pop_front();
      else m_cur = 0;
    end
  end

  // Per-cycle comparison of the DUT against the model, plus exclusion and latency checks.
  int         lat_cnt = 0;
  bit         lat_armed = 0;
  logic [3:0] lat_op = 4'd0;

  always @(negedge clk) begin
    if (!reboot) begin
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_outputs", int'(dut_out), 0);
      lat_armed = 0;
    end else begin
      checkOutput("state", int'(state), m_cur);
      checkOutput("outputs", int'(dut_out), int'(expOut(m_cur, m_op, zero_flag)));
      checkOutput("memrd_memwr_excl", int'(MemRead & MemWrite), 0);
      checkOutput("regwr_memwr_excl", int'(RegWrite & MemWrite), 0);
      checkOutput("irwrite_only_fetch", int'(IRWrite & (state != 4'd0)), 0);
      if (state == 4'd1) lat_op = opcode;
      if (state == 4'd0) begin
        if (lat_armed) checkOutput("latency", lat_cnt, latency(lat_op));
        lat_armed = 1;
        lat_cnt = 1;
      end else lat_cnt++;
    end
  end

  // Runs one instruction from a FETCH negedge, pinning states and key fields to literals.
  task automatic applyStimulus(input logic [3:0] op, input logic z, input int seq[4], input int n);
    opcode = op;
    zero_flag = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("lit_state", int'(state), seq[i]);
      case (seq[i])
        2: begin
          checkOutput("lit_exec_r_srca", int'(ALUSrcA), 1);
          checkOutput("lit_exec_r_srcb", int'(ALUSrcB), 0);
          checkOutput("lit_exec_r_aluop", int'(ALUOp), int'(op));
        end
        4: begin
          checkOutput("lit_alu_wb_regwrite", int'(RegWrite), 1);
          checkOutput("lit_alu_wb_memtoreg", int'(MemtoReg), 0);
          checkOutput("lit_alu_wb_enable", int'(writeback_alu_enable), 1);
        end
        5: begin
          checkOutput("lit_mem_rd_iord", int'(IorD), 1);
          checkOutput("lit_mem_rd_memread", int'(MemRead), 1);
          checkOutput("lit_mem_rd_srcb", int'(ALUSrcB), 2);
        end
        6: begin
          checkOutput("lit_load_wb_regwrite", int'(RegWrite), 1);
          checkOutput("lit_load_wb_memtoreg", int'(MemtoReg), 1);
        end
        7: begin
          checkOutput("lit_mem_wr_memwrite", int'(MemWrite), 1);
          checkOutput("lit_mem_wr_regwrite", int'(RegWrite), 0);
        end
        8: begin
          checkOutput("lit_branch_pcwrite", int'(PCWrite), int'(z));
          checkOutput("lit_branch_pcsource", int'(PCSource), 1);
          checkOutput("lit_branch_aluop", int'(ALUOp), 1);
        end
        9: begin
          checkOutput("lit_jump_pcwrite", int'(PCWrite), 1);
          checkOutput("lit_jump_pcsource", int'(PCSource), 2);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int hold;
    // Reset held for two cycles, then released mid-cycle.
    repeat (2) begin
      @(negedge clk);
      checkOutput("lit_reset_state", int'(state), 0);
      checkOutput("lit_reset_outputs", int'(dut_out), 0);
    end
    @(posedge clk); #2;
    reboot = 1'b1;
    #1;
    checkOutput("lit_release_irwrite", int'(IRWrite), 1);
    checkOutput("lit_release_pcwrite", int'(PCWrite), 1);
    checkOutput("lit_release_pcsource", int'(PCSource), 0);
    @(negedge clk);
    checkOutput("lit_first_fetch", int'(state), 0);

    applyStimulus(4'd0,  1'b0, '{1, 2, 4, 0}, 4);   // ADD
    applyStimulus(4'd3,  1'b1, '{1, 2, 4, 0}, 4);   // OR
    applyStimulus(4'd6,  1'b0, '{1, 5, 6, 0}, 4);   // LW
    applyStimulus(4'd7,  1'b0, '{1, 7, 0, 0}, 3);   // SW
    applyStimulus(4'd8,  1'b1, '{1, 8, 0, 0}, 3);   // BEQ taken
    applyStimulus(4'd8,  1'b0, '{1, 8, 0, 0}, 3);   // BEQ not taken
    applyStimulus(4'd9,  1'b0, '{1, 9, 0, 0}, 3);   // JMP
    applyStimulus(4'd12, 1'b0, '{1, 0, 0, 0}, 2);   // NOP
    applyStimulus(4'd15, 1'b1, '{1, 10, 0, 0}, 2);  // HALT

    // HALT holds with PCWrite low even while zero_flag is high.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("lit_halt_state", int'(state), 10);
      checkOutput("lit_halt_pcwrite", int'(PCWrite), 0);
    end
    #1 reboot = 1'b0;
    @(negedge clk);
    checkOutput("lit_halt_exit_state", int'(state), 0);
    @(posedge clk); #2;
    reboot = 1'b1;
    @(negedge clk);
    checkOutput("lit_after_halt_fetch", int'(state), 0);

    // Reset in the middle of a store drops MemWrite at once.
    applyStimulus(4'd7, 1'b0, '{1, 7, 0, 0}, 2);
    #1 reboot = 1'b0;
    #1;
    checkOutput("lit_abort_memwrite", int'(MemWrite), 0);
    checkOutput("lit_abort_state", int'(state), 0);
    @(posedge clk); #2;
    reboot = 1'b1;
    @(negedge clk);
    checkOutput("lit_abort_fetch", int'(state), 0);

    // Randomized phase: opcode and zero flag change every cycle, occasional resets.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      opcode = 4'($urandom_range(0, 15));
      zero_flag = 1'($urandom_range(0, 1));
      if (!reboot) begin
        if (hold == 0) reboot = 1'b1;
        else hold--;
      end else if ((m_cur == 10 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        reboot = 1'b0;
        hold = $urandom_range(0, 1);
      end
    end
    @(posedge clk); #2;
    reboot = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
